cmp_unit: RTL and testbench

CMP_UNIT -- requirements
Module: cmp_unit

---
 rtl/cmp_unit.sv | 125 ++++++++++++
 tb/tb_cmp_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/cmp_unit.sv
// cmp_unit: multi-cycle chunked subtract/compare unit with valid/ready handshakes
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready, op1, op2, signed_mode : operand channel
//   out_valid/out_ready, result, equal/greater/less : result channel
//   busy : high while an operation is in CALC or HOLD
module cmp_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             greater,
    output logic             less,
    output logic             busy
);
    localparam int NCHUNK = CHUNK > 0 ? WIDTH / CHUNK : 1;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || WIDTH < 2 || WIDTH % (CHUNK < 1 ? 1 : CHUNK) != 0) begin : g_bad_params
            $error("cmp_unit: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0]       a_sr, b_sr, acc, acc_n;
    logic [CW-1:0]          cnt;
    logic                   a_msb, b_msb, sm, borrow;
    logic [CHUNK:0]         diff;
    logic [WIDTH+CHUNK-1:0] cat;
    logic                   last, eq, lt, n, v;

    assign in_ready  = rst && state == IDLE;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;

    // Operands shift right so the active slice is always the low CHUNK bits;
    // finished slices enter acc from the top, so after NCHUNK cycles acc is in order.
    always_comb begin
        diff  = {1'b0, a_sr[CHUNK-1:0]} - {1'b0, b_sr[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow};
        cat   = {diff[CHUNK-1:0], acc};
        acc_n = cat[WIDTH+CHUNK-1:CHUNK];
        last  = cnt == LAST;
        eq    = acc_n == '0;
        n     = acc_n[WIDTH-1];
        v     = (a_msb != b_msb) && (n != a_msb);
        lt    = sm ? n ^ v : diff[CHUNK];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? CALC : IDLE;
            CALC:    state_n = last ? HOLD : CALC;
            HOLD:    state_n = out_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sm      <= 1'b0;
            borrow  <= 1'b0;
            result  <= '0;
            equal   <= 1'b0;
            greater <= 1'b0;
            less    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr   <= op1;
                    b_sr   <= op2;
                    a_msb  <= op1[WIDTH-1];
                    b_msb  <= op2[WIDTH-1];
                    sm     <= signed_mode;
                    borrow <= 1'b0;
                    cnt    <= '0;
                end
                CALC: begin
                    a_sr   <= a_sr >> CHUNK;
                    b_sr   <= b_sr >> CHUNK;
                    acc    <= acc_n;
                    borrow <= diff[CHUNK];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result  <= acc_n;
                        equal   <= eq;
                        less    <= !eq && lt;
                        greater <= !eq && !lt;
                    end
                end
                HOLD: if (out_ready) begin
                    equal   <= 1'b0;
                    greater <= 1'b0;
                    less    <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_unit.sv
// tb_cmp_unit: directed self-checking bench for cmp_unit (WIDTH=16, CHUNK=4)
module tb_cmp_unit;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, signed_mode = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, equal, greater, less, busy;
    logic [15:0] op1 = '0, op2 = '0, result;
    int          nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    cmp_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .equal(equal), .greater(greater), .less(less), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // f = {equal, greater, less}
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] r, input logic [2:0] f);
        op1 = a; op2 = b; signed_mode = s; in_valid = 1'b1;
        step;
        in_valid = 1'b0; op1 = ~a; op2 = ~b; signed_mode = ~s;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_calc"}, in_ready, 0);
        check({tag, "_valid_e0"}, out_valid, 0);
        check({tag, "_flags_calc"}, {equal, greater, less}, 0);
        for (int i = 1; i < 4; i++) begin
            step;
            check({tag, "_valid_early"}, out_valid, 0);
        end
        step;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, result, r);
        check({tag, "_flags"}, {equal, greater, less}, f);
        if (out_ready) begin
            step;
            check({tag, "_valid_after"}, out_valid, 0);
            check({tag, "_in_ready_after"}, in_ready, 1);
            check({tag, "_result_held"}, result, r);
            check({tag, "_flags_after"}, {equal, greater, less}, 0);
        end
    endtask

    initial begin
        step;
        step;
        check("rst_result", result, 0);
        check("rst_flags", {equal, greater, less}, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("in_ready_idle", in_ready, 1);

        run("eq_uns",   16'h000B, 16'h000B, 1'b0, 16'h0000, 3'b100);
        run("ff_uns",   16'hF00F, 16'h0FF0, 1'b0, 16'hE01F, 3'b010);
        run("ff_sgn",   16'hF00F, 16'h0FF0, 1'b1, 16'hE01F, 3'b001);
        run("zm1_uns",  16'h0000, 16'hFFFF, 1'b0, 16'h0001, 3'b001);
        run("zm1_sgn",  16'h0000, 16'hFFFF, 1'b1, 16'h0001, 3'b010);
        run("ovf_uns",  16'h8000, 16'h7FFF, 1'b0, 16'h0001, 3'b010);
        run("ovf_sgn",  16'h8000, 16'h7FFF, 1'b1, 16'h0001, 3'b001);
        run("wrap_uns", 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 3'b001);
        run("eq_sgn",   16'h8000, 16'h8000, 1'b1, 16'h0000, 3'b100);

        out_ready = 1'b0;
        run("hold", 16'h0005, 16'h0003, 1'b0, 16'h0002, 3'b010);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] == 1'b0;
            op1 = 16'h1111; op2 = 16'h2222; signed_mode = 1'b1;
            step;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, 16'h0002);
            check("hold_flags", {equal, greater, less}, 3'b010);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        check("hs_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_busy", busy, 0);
        check("hs_result", result, 16'h0002);

        op1 = 16'h00FF; op2 = 16'h0001; signed_mode = 1'b0; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b0;
        step;
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", {equal, greater, less}, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        run("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
